// File: rtl/ps2_scan_sequencer.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, frames 11-bit
// packets on falling clock edges, validates start/parity/stop, folds the
// E0/F0 prefixes into flags and queues key events for a valid/ack consumer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | bus quiet, waiting for the start-bit falling edge
// RECEIVE | shifting bits 1..10 in, timeout timer running
// CHECK   | one cycle: start/parity/stop validation
// DECODE  | one cycle: prefix folding or event push
module ps2_scan_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2_Clk,
  input  logic       iPS2_Data,
  input  logic       iAck,
  output logic [7:0] oKey_Code,
  output logic       oKey_Extended,
  output logic       oKey_Break,
  output logic       oKey_Valid,
  output logic       oFrame_Error,
  output logic       oOverflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RECEIVE, CHECK, DECODE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;
  logic [3:0]             bit_cnt;
  logic [10:0]            shift_q;
  logic [TW-1:0]          tmo_cnt;
  logic                   ext_q;
  logic                   brk_q;
  logic                   push_q;
  logic [9:0]             push_word;
  logic                   frame_ok;

  logic [9:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   pop;
  logic                   do_push;
  logic [9:0]             head;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall = clk_prev & ~clk_s;

  // Frame layout after 11 LSB-first shifts: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign frame_ok = ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);

  // Synchronise the asynchronous PS/2 lines; flops rest at the idle-high bus level.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], iPS2_Clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], iPS2_Data};
      clk_prev  <= clk_s;
    end
  end

  // Frame reception FSM with abort timer and prefix folding.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      bit_cnt      <= 4'd0;
      shift_q      <= 11'd0;
      tmo_cnt      <= TMO_LOAD;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      push_q       <= 1'b0;
      push_word    <= 10'd0;
      oFrame_Error <= 1'b0;
    end else begin
      oFrame_Error <= 1'b0;
      push_q       <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= TMO_LOAD;
          if (fall) begin
            shift_q <= {data_s, shift_q[10:1]};
            bit_cnt <= 4'd1;
            state   <= RECEIVE;
          end
        end
        RECEIVE: begin
          if (fall) begin
            shift_q <= {data_s, shift_q[10:1]};
            bit_cnt <= bit_cnt + 4'd1;
            tmo_cnt <= TMO_LOAD;
            if (bit_cnt == 4'd10) state <= CHECK;
          end else if (tmo_cnt == '0) begin
            // Keyboard stalled mid-frame: drop the partial frame and any pending prefix.
            oFrame_Error <= 1'b1;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            bit_cnt      <= 4'd0;
            state        <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
        end
        CHECK: begin
          bit_cnt <= 4'd0;
          if (frame_ok) begin
            state <= DECODE;
          end else begin
            oFrame_Error <= 1'b1;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            state        <= IDLE;
          end
        end
        DECODE: begin
          if (shift_q[8:1] == 8'hE0) begin
            ext_q <= 1'b1;
          end else if (shift_q[8:1] == 8'hF0) begin
            brk_q <= 1'b1;
          end else begin
            push_q    <= 1'b1;
            push_word <= {ext_q, brk_q, shift_q[8:1]};
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full    = (count == FIFO_FULL);
  assign pop     = iAck && (count != '0);
  assign do_push = push_q && (!full || pop);

  // Event storage; contents are only visible through the valid-gated head.
  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      oOverflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_q && full && !pop) oOverflow <= 1'b1;
    end
  end

  assign head          = mem[rd_ptr];
  assign oKey_Valid    = (count != '0);
  assign oKey_Code     = oKey_Valid ? head[7:0] : 8'd0;
  assign oKey_Break    = oKey_Valid & head[8];
  assign oKey_Extended = oKey_Valid & head[9];

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed bench for ps2_scan_sequencer: drives PS/2 frames bit by bit and
// checks events, frame errors, timeout, overflow and reset behaviour.
module tb_ps2_scan_sequencer;

  localparam int TMO  = 200;
  localparam int HALF = 10;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] code;
  logic       ext;
  logic       brk;
  logic       valid;
  logic       ferr;
  logic       ovf;

  int tests = 0;
  int failed = 0;
  int err_cycles = 0;
  int err_rises = 0;
  logic err_prev = 1'b0;
  int e0;
  int c0;
  logic [10:0] f;

  ps2_scan_sequencer #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH(4)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .iPS2_Clk(ps2_clk),
    .iPS2_Data(ps2_data),
    .iAck(ack),
    .oKey_Code(code),
    .oKey_Extended(ext),
    .oKey_Break(brk),
    .oKey_Valid(valid),
    .oFrame_Error(ferr),
    .oOverflow(ovf)
  );

  always #5 Clock = ~Clock;

  // Count frame-error pulses and the cycles they stay high.
  always @(negedge Clock) begin
    if (ferr) err_cycles++;
    if (ferr && !err_prev) err_rises++;
    err_prev = ferr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic flip_par, input logic stop);
    return {stop, (~^d) ^ flip_par, d, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b);
    @(negedge Clock);
    ps2_data = b;
    repeat (HALF) @(negedge Clock);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge Clock);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) ps2_bit(fr[i]);
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bits(frame(d, 1'b0, 1'b1), 11);
  endtask

  task automatic pop_event(input string tag, input logic [7:0] c, input logic e, input logic b);
    chk({tag, "_valid"}, valid, 1'b1);
    chk({tag, "_code"}, code, c);
    chk({tag, "_ext"}, ext, e);
    chk({tag, "_brk"}, brk, b);
    @(negedge Clock);
    ack = 1'b1;
    @(negedge Clock);
    ack = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    failed++;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    // Reset state
    repeat (3) @(negedge Clock);
    chk("rst_valid", valid, 1'b0);
    chk("rst_outs", {code, ext, brk, ferr, ovf}, 12'd0);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);

    // 0x1C with latency check on the stop edge
    f = frame(8'h1C, 1'b0, 1'b1);
    send_bits(f, 10);
    @(negedge Clock);
    ps2_data = f[10];
    repeat (HALF) @(negedge Clock);
    ps2_clk = 1'b0;
    repeat (5) @(posedge Clock);
    #1 chk("lat_before", valid, 1'b0);
    @(posedge Clock);
    #1 chk("lat_at3", valid, 1'b1);
    repeat (HALF) @(negedge Clock);
    ps2_clk = 1'b1;
    pop_event("ev1c", 8'h1C, 1'b0, 1'b0);
    @(negedge Clock);
    chk("ack_drop", valid, 1'b0);

    // Ack while empty is ignored
    @(negedge Clock);
    ack = 1'b1;
    @(negedge Clock);
    ack = 1'b0;
    chk("empty_ack_valid", valid, 1'b0);
    chk("empty_ack_ovf", ovf, 1'b0);

    // F0 prefix gives no event, then break event
    send_byte(8'hF0);
    chk("f0_noevent", valid, 1'b0);
    send_byte(8'h1C);
    pop_event("brk1c", 8'h1C, 1'b0, 1'b1);

    // E0 F0 74 then plain 74
    send_byte(8'hE0);
    send_byte(8'hF0);
    chk("e0f0_noevent", valid, 1'b0);
    send_byte(8'h74);
    pop_event("extbrk74", 8'h74, 1'b1, 1'b1);
    send_byte(8'h74);
    pop_event("plain74", 8'h74, 1'b0, 1'b0);

    // Parity error
    e0 = err_rises; c0 = err_cycles;
    send_bits(frame(8'h1C, 1'b1, 1'b1), 11);
    chk("par_err_pulses", err_rises - e0, 1);
    chk("par_err_width", err_cycles - c0, 1);
    chk("par_noevent", valid, 1'b0);

    // Stop bit low
    e0 = err_rises; c0 = err_cycles;
    send_bits(frame(8'h1C, 1'b0, 1'b0), 11);
    chk("stop_err_pulses", err_rises - e0, 1);
    chk("stop_err_width", err_cycles - c0, 1);
    chk("stop_noevent", valid, 1'b0);

    // Timeout after a partial frame
    e0 = err_rises; c0 = err_cycles;
    send_bits(frame(8'h1C, 1'b0, 1'b1), 6);
    repeat (TMO - 40) @(negedge Clock);
    chk("tmo_early", err_rises - e0, 0);
    repeat (60) @(negedge Clock);
    chk("tmo_pulses", err_rises - e0, 1);
    chk("tmo_width", err_cycles - c0, 1);
    chk("tmo_noevent", valid, 1'b0);
    send_byte(8'h1C);
    pop_event("after_tmo", 8'h1C, 1'b0, 1'b0);

    // Overflow: five codes, four kept in order
    send_byte(8'h15);
    send_byte(8'h1D);
    send_byte(8'h24);
    send_byte(8'h2D);
    chk("full_no_ovf", ovf, 1'b0);
    send_byte(8'h2C);
    chk("ovf_set", ovf, 1'b1);
    pop_event("q0", 8'h15, 1'b0, 1'b0);
    pop_event("q1", 8'h1D, 1'b0, 1'b0);
    pop_event("q2", 8'h24, 1'b0, 1'b0);
    pop_event("q3", 8'h2D, 1'b0, 1'b0);
    @(negedge Clock);
    chk("q_empty", valid, 1'b0);
    chk("ovf_sticky", ovf, 1'b1);

    // Reset mid-frame with a non-empty FIFO
    send_byte(8'h5A);
    send_bits(frame(8'h33, 1'b0, 1'b1), 4);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_ovf", ovf, 1'b0);
    chk("midrst_outs", {code, ext, brk, ferr}, 11'd0);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    send_byte(8'h1C);
    pop_event("post_rst", 8'h1C, 1'b0, 1'b0);
    @(negedge Clock);
    chk("post_rst_empty", valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ps2_scan_sequencer.md
Name: ps2_scan_sequencer

Overview:
Sequences reception of PS/2 keyboard frames and turns raw scan bytes into key events. It synchronises the PS/2 clock/data lines into the system clock domain and shifts the 11-bit frame on detected falling edges. It checks start/parity/stop, folds E0/F0 prefixes into extended/break flags, and buffers events in a small FIFO drained by a valid/ack handshake. It sits between the keyboard pins and the consumer logic (display/character mapping).

Parameters:
SYNC_STAGES, 2, flip-flop stages on iPS2_Clk and iPS2_Data (minimum 2).
TIMEOUT_CYCLES, 50000, Clock cycles with no PS2 falling edge before a partial frame is aborted (1 ms at 50 MHz).
FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2).

Ports:
Clock  input  1  system clock, all logic on rising edge.
Reset  input  1  asynchronous, active-low reset.
iPS2_Clk  input  1  raw PS/2 clock from keyboard, asynchronous.
iPS2_Data  input  1  raw PS/2 data from keyboard, asynchronous.
iAck  input  1  consumer pops the head event; honoured only while oKey_Valid=1.
oKey_Code  output  8  scan code of the head event.
oKey_Extended  output  1  head event was preceded by E0.
oKey_Break  output  1  head event was preceded by F0 (key release).
oKey_Valid  output  1  FIFO not empty.
oFrame_Error  output  1  one-cycle pulse on bad start/parity/stop or timeout.
oOverflow  output  1  sticky; event dropped because FIFO was full.

Behaviour:
- Reset (Reset=0, async): FSM=IDLE, bit count=0, shift reg=0, prefix flags=0, FIFO empty. All outputs 0. Synchroniser flops reset to 1 (idle bus level).
- Edge detect: falling edge = previous synced clk 1, current 0; one-cycle pulse. Data is sampled from the synced data line in the same cycle.
- FSM states: IDLE, RECEIVE, CHECK, DECODE.
- IDLE: on edge pulse, capture bit 0, count=1, go RECEIVE. Timeout counter is cleared.
- RECEIVE: each edge pulse shifts in the next bit (LSB first) and increments count. The edge carrying bit 10 (stop) goes to CHECK. Timeout counter increments each cycle and clears on each edge. When it reaches TIMEOUT_CYCLES-1: pulse oFrame_Error, clear prefix flags, go IDLE.
- CHECK (1 cycle): a frame is valid iff start=0, stop=1, and data plus parity has an odd number of ones. Invalid: pulse oFrame_Error, clear prefix flags, go IDLE. Valid: go DECODE.
- DECODE (1 cycle):
  - byte E0: set extended flag.
  - byte F0: set break flag.
  - any other byte: push {extended, break, byte} to the FIFO, then clear both flags.
  - Always go IDLE.
- Latency: oKey_Valid rises 3 Clock cycles after the stop-bit edge pulse (CHECK, DECODE/push, registered FIFO status).
- Edges arriving during CHECK/DECODE are ignored. PS/2 bit period far exceeds 2 cycles.
- FIFO: head is presented on oKey_Code/oKey_Extended/oKey_Break while oKey_Valid=1; these are 0 when empty.
  - iAck with valid pops the head. iAck while empty is ignored.
- FIFO full: a push with no pop drops the event and sets oOverflow (held until reset). Push and pop in the same cycle while full: both succeed, no overflow. Push and pop while it holds 1 entry: the new entry becomes head and oKey_Valid stays 1.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- Reset mid-frame or with a non-empty FIFO: everything is discarded immediately. The first frame after reset release starts cleanly.

Test Plan:
- Send 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1; parity 0) -> one event: code 0x1C, ext 0, brk 0, oKey_Valid 3 cycles after stop edge; iAck -> valid drops.
- Send F0 (parity 1), then 0x1C -> exactly one event: code 0x1C, brk 1, ext 0. No event for F0.
- Send E0 (parity 0), F0, 0x74 (parity 1) -> one event: code 0x74, ext 1, brk 1. A following 0x74 gives ext 0, brk 0.
- Send 0x1C with parity forced to 1 -> oFrame_Error pulses 1 cycle, no event. Repeat with stop=0 -> same.
- Send 6 bits, then hold the bus for TIMEOUT_CYCLES -> oFrame_Error pulse, FSM back in IDLE. A subsequent valid 0x1C is received correctly.
- Send 5 codes with no iAck (FIFO_DEPTH=4) -> 4 events retained in order, oOverflow=1. Assert Reset mid-frame -> all outputs 0, oOverflow cleared.
